// File: rtl/alu_seq_module_if.sv
// Operand/handshake/flag bundle for alu_seq_module.
// The master side (controller or bench) drives start/op/a/b/oe; the ALU
// drives busy/done and the four status flags. The shared data bus stays a
// plain inout port on the ALU so its tri-state driver is visible at top level.
interface alu_seq_module_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             oe;
    logic             busy;
    logic             done;
    logic             zf;
    logic             cf;
    logic             nf;
    logic             vf;

    modport master (
        output start, op, a, b, oe,
        input  busy, done, zf, cf, nf, vf
    );

    modport slave (
        input  start, op, a, b, oe,
        output busy, done, zf, cf, nf, vf
    );
endinterface

// File: rtl/alu_seq_module.sv
// Registered sequential ALU: operands are captured on start, executed by a
// small FSM (IDLE -> EXEC/MUL -> DONE -> IDLE), and the result register drives
// the shared tri-state bus whenever oe is high.
// Optional feature macro: ALU_MUL_EN enables the iterative shift-add multiplier
// on op 111. Without it, op 111 is a NOP that still produces a done pulse.
module alu_seq_module #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_module_if.slave  alu,
    inout  wire [WIDTH-1:0]  bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_ADC = 3'b010,
        OP_SBC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;
    localparam int CNT_W = $clog2(WIDTH + 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
`endif

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zf_q, zf_d;
    logic             cf_q, cf_d;
    logic             nf_q, nf_d;
    logic             vf_q, vf_d;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
`endif

    // Single-cycle datapath results for the op latched in op_q.
    logic             cin_eff;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] exec_res;
    logic             exec_cf;
    logic             exec_vf;
    logic             exec_wr;

    // Adder/subtractor shared by the carry and non-carry variants.
    always_comb begin
        cin_eff  = ((op_q == OP_ADC) || (op_q == OP_SBC)) && cin_q;
        add_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_eff};
        // Bit WIDTH of the wrapped difference is the borrow (a < b + cin).
        sub_full = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_eff};
    end

    // Select result and carry/overflow for the latched op; op 111 writes nothing here.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path through the case leaves it unassigned, which would infer a latch.
        exec_wr  = 1'b1;
        exec_res = '0;
        exec_cf  = 1'b0;
        exec_vf  = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC: begin
                exec_res = add_full[WIDTH-1:0];
                exec_cf  = add_full[WIDTH];
                exec_vf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (exec_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                exec_res = sub_full[WIDTH-1:0];
                exec_cf  = sub_full[WIDTH];
                exec_vf  = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                           (exec_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_XOR:  exec_res = a_q ^ b_q;
            default: exec_wr  = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    // One shift-add step: add multiplicand to the upper half if the current
    // multiplier LSB is set, then shift the whole product right by one.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        mul_step = {mul_sum, prod_q[WIDTH-1:1]};
    end
`endif

    // Next-state, operand capture and result/flag update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        result_d = result_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        nf_d     = nf_q;
        vf_d     = vf_q;
`ifdef ALU_MUL_EN
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (alu.start) begin
                    op_d    = op_e'(alu.op);
                    a_d     = alu.a;
                    b_d     = alu.b;
                    cin_d   = cf_q;
                    state_d = S_EXEC;
`ifdef ALU_MUL_EN
                    if (alu.op == OP_MUL) begin
                        state_d = S_MUL;
                        cnt_d   = CNT_W'(WIDTH);
                        prod_d  = {{WIDTH{1'b0}}, alu.b};
                    end
`endif
                end
            end
            S_EXEC: begin
                if (exec_wr) begin
                    result_d = exec_res;
                    zf_d     = (exec_res == '0);
                    cf_d     = exec_cf;
                    nf_d     = exec_res[WIDTH-1];
                    vf_d     = exec_vf;
                end
                state_d = S_DONE;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                // WIDTH step cycles, then one write-back cycle at count zero.
                if (cnt_q != '0) begin
                    prod_d = mul_step;
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    result_d = prod_q[WIDTH-1:0];
                    zf_d     = (prod_q[WIDTH-1:0] == '0);
                    cf_d     = |prod_q[2*WIDTH-1:WIDTH];
                    nf_d     = prod_q[WIDTH-1];
                    vf_d     = 1'b0;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking assignments so
        // every flop samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            nf_q     <= 1'b0;
            vf_q     <= 1'b0;
`ifdef ALU_MUL_EN
            prod_q   <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            nf_q     <= nf_d;
            vf_q     <= vf_d;
`ifdef ALU_MUL_EN
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Status outputs decoded from the state register; flags come straight from flops.
`ifdef ALU_MUL_EN
    assign alu.busy = (state_q == S_EXEC) || (state_q == S_MUL);
`else
    assign alu.busy = (state_q == S_EXEC);
`endif
    assign alu.done = (state_q == S_DONE);
    assign alu.zf   = zf_q;
    assign alu.cf   = cf_q;
    assign alu.nf   = nf_q;
    assign alu.vf   = vf_q;

    // Result register drives the shared bus only under oe, stale value included.
    assign bus = alu.oe ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq_module.sv
// Directed-vector bench for alu_seq_module (WIDTH=8). Expected values are
// hand-computed constants. When the bench releases the bus it drives a known
// pattern itself, so any DUT drive with oe=0 corrupts the observed value.
module tb_alu_seq_module;

    localparam int W = 8;

    logic clk;
    logic rst;
    wire  [W-1:0] bus;
    logic         tb_drv_en;
    logic [W-1:0] tb_drv_val;

    int checks;
    int errors;

    alu_seq_module_if #(.WIDTH(W)) intf ();

    alu_seq_module #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .alu (intf.slave),
        .bus (bus)
    );

    assign bus = tb_drv_en ? tb_drv_val : {W{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ADC = 3'b010, SBC = 3'b011;
    localparam logic [2:0] AND_ = 3'b100, OR_ = 3'b101, XOR_ = 3'b110, MUL = 3'b111;

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; lat = cycle (1 = first after the start edge) where done
    // is seen, or -1 on timeout; one further step returns the DUT to IDLE.
    task automatic run_op(input logic [2:0] op_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, output int lat, output int busy_cycles);
        intf.op    = op_i;
        intf.a     = a_i;
        intf.b     = b_i;
        intf.start = 1'b1;
        step();
        intf.start  = 1'b0;
        lat         = 1;
        busy_cycles = 0;
        while (intf.done !== 1'b1 && lat < 40) begin
            if (intf.busy === 1'b1) busy_cycles++;
            step();
            lat++;
        end
        if (intf.done !== 1'b1) lat = -1;
        step();
    endtask

    // Read the result register through the bus with oe asserted.
    task automatic read_bus(output logic [W-1:0] v);
        tb_drv_en = 1'b0;
        intf.oe   = 1'b1;
        #1;
        v       = bus;
        intf.oe = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] r;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({intf.busy, intf.done, intf.zf, intf.cf, intf.nf, intf.vf} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status: got busy,done,zf,cf,nf,vf=%b expected 000000",
                     {intf.busy, intf.done, intf.zf, intf.cf, intf.nf, intf.vf});
        end
        read_bus(r);
        checks++;
        if (r !== 8'h00) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00", r);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        int lat, bc;
        logic [W-1:0] r;
        run_op(ADD, 8'd200, 8'd100, lat, bc);
        checks++;
        if (lat != 2 || bc != 1) begin
            errors++;
            $display("FAIL add_latency: got lat=%0d busy=%0d expected lat=2 busy=1", lat, bc);
        end
        read_bus(r);
        checks++;
        if (r !== 8'h2C) begin
            errors++;
            $display("FAIL add_result: got %h expected 2c", r);
        end
        checks++;
        if ({intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b0100) begin
            errors++;
            $display("FAIL add_flags: got zcnv=%b expected 0100",
                     {intf.zf, intf.cf, intf.nf, intf.vf});
        end
        // Bus released with oe=0: only the bench's own pattern must be seen.
        tb_drv_val = 8'h00;
        tb_drv_en  = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h00) begin
            errors++;
            $display("FAIL bus_release: got %h expected 00 (bench drive only)", bus);
        end
        tb_drv_en = 1'b0;
    endtask

    task automatic test_sub();
        int lat, bc;
        logic [W-1:0] r;
        run_op(SUB, 8'd5, 8'd5, lat, bc);
        read_bus(r);
        checks++;
        if (lat != 2 || r !== 8'h00 || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b1000) begin
            errors++;
            $display("FAIL sub_equal: got lat=%0d r=%h zcnv=%b expected lat=2 r=00 zcnv=1000",
                     lat, r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
        run_op(SUB, 8'd3, 8'd5, lat, bc);
        read_bus(r);
        checks++;
        if (r !== 8'hFE || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b0110) begin
            errors++;
            $display("FAIL sub_borrow: got r=%h zcnv=%b expected r=fe zcnv=0110",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
        // cf=1 from the borrow feeds SBC: 0x80 - 0 - 1 = 0x7F, signed overflow.
        run_op(SBC, 8'h80, 8'h00, lat, bc);
        read_bus(r);
        checks++;
        if (r !== 8'h7F || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b0001) begin
            errors++;
            $display("FAIL sbc_overflow: got r=%h zcnv=%b expected r=7f zcnv=0001",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
    endtask

    task automatic test_carry();
        int lat, bc;
        logic [W-1:0] r;
        run_op(ADD, 8'd255, 8'd1, lat, bc);
        read_bus(r);
        checks++;
        if (r !== 8'h00 || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b1100) begin
            errors++;
            $display("FAIL add_wrap: got r=%h zcnv=%b expected r=00 zcnv=1100",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
        run_op(ADC, 8'd0, 8'd0, lat, bc);
        read_bus(r);
        checks++;
        if (r !== 8'h01 || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b0000) begin
            errors++;
            $display("FAIL adc_cin: got r=%h zcnv=%b expected r=01 zcnv=0000",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
        run_op(ADD, 8'd127, 8'd1, lat, bc);
        read_bus(r);
        checks++;
        if (r !== 8'h80 || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b0011) begin
            errors++;
            $display("FAIL add_overflow: got r=%h zcnv=%b expected r=80 zcnv=0011",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
    endtask

    task automatic test_logic();
        int lat, bc;
        logic [W-1:0] r;
        run_op(OR_, 8'hA5, 8'h5A, lat, bc);
        read_bus(r);
        checks++;
        if (r !== 8'hFF || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b0010) begin
            errors++;
            $display("FAIL or_op: got r=%h zcnv=%b expected r=ff zcnv=0010",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
        run_op(XOR_, 8'hFF, 8'h0F, lat, bc);
        read_bus(r);
        checks++;
        if (r !== 8'hF0 || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b0010) begin
            errors++;
            $display("FAIL xor_op: got r=%h zcnv=%b expected r=f0 zcnv=0010",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [W-1:0] r;
        run_op(ADD, 8'd255, 8'd1, lat, bc);   // leaves cf=1
        intf.op    = AND_;
        intf.a     = 8'hF0;
        intf.b     = 8'h0F;
        intf.start = 1'b1;
        step();                               // now in EXEC
        intf.op = ADD;                        // start held high with new operands
        intf.a  = 8'h01;
        intf.b  = 8'h01;
        step();                               // now in DONE
        checks++;
        if (intf.done !== 1'b1 || intf.busy !== 1'b0) begin
            errors++;
            $display("FAIL and_done: got done=%b busy=%b expected done=1 busy=0",
                     intf.done, intf.busy);
        end
        step();                               // start in DONE must be ignored
        intf.start = 1'b0;
        checks++;
        if (intf.done !== 1'b0 || intf.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: got done=%b busy=%b expected done=0 busy=0",
                     intf.done, intf.busy);
        end
        step();
        read_bus(r);
        checks++;
        if (intf.done !== 1'b0 || r !== 8'h00 ||
            {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b1000) begin
            errors++;
            $display("FAIL and_result: got done=%b r=%h zcnv=%b expected done=0 r=00 zcnv=1000",
                     intf.done, r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
    endtask

    task automatic test_mul();
        int lat, bc;
        logic [W-1:0] r;
`ifdef ALU_MUL_EN
        run_op(MUL, 8'd15, 8'd17, lat, bc);
        read_bus(r);
        checks++;
        if (lat != 10 || bc != 9) begin
            errors++;
            $display("FAIL mul_latency: got lat=%0d busy=%0d expected lat=10 busy=9", lat, bc);
        end
        checks++;
        if (r !== 8'hFF || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b0010) begin
            errors++;
            $display("FAIL mul_15x17: got r=%h zcnv=%b expected r=ff zcnv=0010",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
        run_op(MUL, 8'd16, 8'd16, lat, bc);
        read_bus(r);
        checks++;
        if (r !== 8'h00 || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b1100) begin
            errors++;
            $display("FAIL mul_16x16: got r=%h zcnv=%b expected r=00 zcnv=1100",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
`else
        run_op(ADD, 8'd127, 8'd1, lat, bc);   // result 80, zcnv=0011
        run_op(MUL, 8'd15, 8'd17, lat, bc);
        read_bus(r);
        checks++;
        if (lat != 2 || bc != 1) begin
            errors++;
            $display("FAIL nop_latency: got lat=%0d busy=%0d expected lat=2 busy=1", lat, bc);
        end
        checks++;
        if (r !== 8'h80 || {intf.zf, intf.cf, intf.nf, intf.vf} !== 4'b0011) begin
            errors++;
            $display("FAIL nop_hold: got r=%h zcnv=%b expected r=80 zcnv=0011",
                     r, {intf.zf, intf.cf, intf.nf, intf.vf});
        end
`endif
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        int stray_done;
        logic [W-1:0] r;
        run_op(ADD, 8'd127, 8'd1, lat, bc);   // non-zero result and flags
        intf.op    = MUL;
        intf.a     = 8'd15;
        intf.b     = 8'd17;
        intf.start = 1'b1;
        step();                               // cycle 1
        intf.start = 1'b0;
        step();                               // cycle 2
        step();                               // cycle 3
        rst = 1'b1;                           // asserted during cycle 4
        step();
        tb_drv_val = 8'h55;
        tb_drv_en  = 1'b1;
        #1;
        checks++;
        if ({intf.busy, intf.done, intf.zf, intf.cf, intf.nf, intf.vf} !== 6'b0 ||
            bus !== 8'h55) begin
            errors++;
            $display("FAIL abort_state: got status=%b bus=%h expected status=000000 bus=55",
                     {intf.busy, intf.done, intf.zf, intf.cf, intf.nf, intf.vf}, bus);
        end
        tb_drv_en = 1'b0;
        read_bus(r);
        checks++;
        if (r !== 8'h00) begin
            errors++;
            $display("FAIL abort_result: got %h expected 00", r);
        end
        rst = 1'b0;
        stray_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (intf.done === 1'b1 || intf.busy === 1'b1) stray_done++;
        end
        checks++;
        if (stray_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", stray_done);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        tb_drv_en  = 1'b0;
        tb_drv_val = '0;
        intf.start = 1'b0;
        intf.op    = 3'b000;
        intf.a     = '0;
        intf.b     = '0;
        intf.oe    = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_carry();
        test_logic();
        test_back_to_back();
        test_mul();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
